// File: rtl/fir_sample_feeder.sv
// Sample feeder for the 80-tap FIR: FIFO-buffered producer samples, one per 21-cycle frame.
// Optional FIR_FEEDER_HOLD_LAST_EN: on underflow repeat the last sample instead of inserting zero.
module fir_sample_feeder #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int FRAME_CYCLES = 21,
  parameter int PRIME_LVL    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run_en,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  output logic [DATA_W-1:0]             fir_sample,
  output logic                          fir_ready,
  output logic                          frame_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          clr_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_CYCLES - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PRIME_THR = (AW + 1)'(PRIME_LVL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [DATA_W-1:0]   sample_reg, sample_next;
  logic                ready_reg, ready_next;
  logic                strobe_reg;
  logic                underflow_reg, underflow_next;
  logic                s_ready_reg;
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]         level_reg, level_next;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   head;
  logic [DATA_W-1:0]   underflow_val;
  logic                push, pop;

  // s_ready is a registered "not full", so a full FIFO never takes a push even when popping
  assign push = s_valid & s_ready_reg;
  assign head = mem[rd_ptr_reg];

`ifdef FIR_FEEDER_HOLD_LAST_EN
  assign underflow_val = sample_reg;
`else
  assign underflow_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    sample_next    = sample_reg;
    ready_next     = ready_reg;
    underflow_next = underflow_reg & ~clr_flags;
    pop            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        sample_next = '0;
        ready_next  = 1'b0;
        cnt_next    = '0;
        if (run_en) begin
          state_next = ST_PRIME;
        end
      end
      ST_PRIME: begin
        sample_next = '0;
        ready_next  = 1'b0;
        cnt_next    = '0;
        if (!run_en) begin
          state_next = ST_IDLE;
        end else if (level_reg >= PRIME_THR) begin
          pop         = 1'b1;
          sample_next = head;
          ready_next  = 1'b1;
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        ready_next = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (!run_en) begin
            state_next  = ST_IDLE;
            ready_next  = 1'b0;
            sample_next = '0;
          end else if (level_reg != '0) begin
            pop         = 1'b1;
            sample_next = head;
          end else begin
            // set has priority over a coincident clr_flags
            underflow_next = 1'b1;
            sample_next    = underflow_val;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      sample_reg    <= '0;
      ready_reg     <= 1'b0;
      strobe_reg    <= 1'b0;
      underflow_reg <= 1'b0;
      s_ready_reg   <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sample_reg    <= sample_next;
      ready_reg     <= ready_next;
      strobe_reg    <= (state_next == ST_RUN) && (cnt_next == LAST_CNT);
      underflow_reg <= underflow_next;
      s_ready_reg   <= (level_next != FULL_LVL);
      level_reg     <= level_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign s_ready      = s_ready_reg;
  assign fir_sample   = sample_reg;
  assign fir_ready    = ready_reg;
  assign frame_strobe = strobe_reg;
  assign fifo_level   = level_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed self-checking bench for fir_sample_feeder: priming, framing, full FIFO,
// underflow and flag clear, stop at boundary, async reset mid-frame, push during pop.
module tb_fir_sample_feeder;

  logic       clk;
  logic       rst_n;
  logic       run_en;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] fir_sample;
  logic       fir_ready;
  logic       frame_strobe;
  logic [3:0] fifo_level;
  logic       underflow;
  logic       clr_flags;

  int n_checks = 0;
  int n_fail   = 0;

  fir_sample_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .fir_sample   (fir_sample),
    .fir_ready    (fir_ready),
    .frame_strobe (frame_strobe),
    .fifo_level   (fifo_level),
    .underflow    (underflow),
    .clr_flags    (clr_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    check("push_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
    $display("push 0x%02h -> level %0d", d, fifo_level);
  endtask

  // advance until the strobe cycle (counter at its last value)
  task automatic wait_boundary();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = frame_strobe;
    end
    check("boundary_seen", 32'(frame_strobe), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] uf_exp;
  int         n05;
  bit         early;

  initial begin
`ifdef FIR_FEEDER_HOLD_LAST_EN
    uf_exp = 8'hFB;
`else
    uf_exp = 8'h00;
`endif
    rst_n     = 1'b0;
    run_en    = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    clr_flags = 1'b0;

    // reset state
    tick();
    check("rst_fir_ready", 32'(fir_ready), 32'd0);
    check("rst_fir_sample", 32'(fir_sample), 32'd0);
    check("rst_strobe", 32'(frame_strobe), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    rst_n  = 1'b1;
    run_en = 1'b1;
    tick();
    check("s_ready_after_rel", 32'(s_ready), 32'd1);

    // prime with two samples, first frame holds 0x05 for 21 cycles
    push(8'h05);
    check("prime1_ready", 32'(fir_ready), 32'd0);
    push(8'hFB);
    check("prime2_level", 32'(fifo_level), 32'd2);
    check("prime2_ready", 32'(fir_ready), 32'd0);
    tick();
    check("run_ready", 32'(fir_ready), 32'd1);
    check("run_sample0", 32'(fir_sample), 32'h05);
    check("run_level", 32'(fifo_level), 32'd1);
    n05   = (fir_sample == 8'h05) ? 1 : 0;
    early = frame_strobe;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (fir_sample == 8'h05 && fir_ready) n05++;
      if (i < 20 && frame_strobe) early = 1'b1;
    end
    check("no_early_strobe", 32'(early), 32'd0);
    check("strobe_21st", 32'(frame_strobe), 32'd1);
    check("hold_05_cycles", 32'(n05), 32'd21);
    tick();
    check("second_sample", 32'(fir_sample), 32'hFB);
    check("strobe_pulse", 32'(frame_strobe), 32'd0);
    check("drained_level", 32'(fifo_level), 32'd0);

    // underflow at next boundary, then clear and set-wins
    wait_boundary();
    tick();
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_sample", 32'(fir_sample), 32'(uf_exp));
    check("uf_ready", 32'(fir_ready), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("uf_cleared", 32'(underflow), 32'd0);
    wait_boundary();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("uf_set_wins", 32'(underflow), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("uf_cleared2", 32'(underflow), 32'd0);

    // push coincident with a boundary pop at level 4
    push(8'h80);
    push(8'h7F);
    push(8'h01);
    push(8'h22);
    check("lvl4", 32'(fifo_level), 32'd4);
    wait_boundary();
    s_valid = 1'b1;
    s_data  = 8'h33;
    tick();
    s_valid = 1'b0;
    $display("push 0x33 at boundary -> level %0d sample 0x%02h", fifo_level, fir_sample);
    check("pushpop_level", 32'(fifo_level), 32'd4);
    check("order_80", 32'(fir_sample), 32'h80);
    wait_boundary();
    tick();
    check("order_7f", 32'(fir_sample), 32'h7F);
    check("order_7f_level", 32'(fifo_level), 32'd3);
    wait_boundary();
    tick();
    check("order_01", 32'(fir_sample), 32'h01);
    check("order_01_level", 32'(fifo_level), 32'd2);
    check("no_uf_while_fed", 32'(underflow), 32'd0);

    // stop request mid-frame takes effect at the boundary only
    for (int i = 0; i < 7; i++) tick();
    run_en = 1'b0;
    check("stop_ready_mid", 32'(fir_ready), 32'd1);
    wait_boundary();
    check("stop_ready_bnd", 32'(fir_ready), 32'd1);
    check("stop_sample_bnd", 32'(fir_sample), 32'h01);
    tick();
    check("stop_ready_off", 32'(fir_ready), 32'd0);
    check("stop_sample_zero", 32'(fir_sample), 32'd0);
    check("stop_level_kept", 32'(fifo_level), 32'd2);
    tick();
    check("idle_ready_off", 32'(fir_ready), 32'd0);

    // async reset mid-frame with level 3
    push(8'h44);
    push(8'h55);
    check("pre_rst_lvl4", 32'(fifo_level), 32'd4);
    run_en = 1'b1;
    tick();
    tick();
    check("restart_sample", 32'(fir_sample), 32'h22);
    check("restart_level", 32'(fifo_level), 32'd3);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-frame");
    check("arst_ready", 32'(fir_ready), 32'd0);
    check("arst_sample", 32'(fir_sample), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_strobe", 32'(frame_strobe), 32'd0);
    check("arst_s_ready", 32'(s_ready), 32'd0);
    run_en = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("rel_s_ready", 32'(s_ready), 32'd1);
    check("rel_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("rel_idle_ready", 32'(fir_ready), 32'd0);

    // fill to full with no run, 9th sample held
    s_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_data = 8'(i);
      tick();
      $display("push 0x%02h -> level %0d s_ready %0d", 8'(i), fifo_level, s_ready);
    end
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_s_ready", 32'(s_ready), 32'd0);
    s_data = 8'h09;
    tick();
    check("full_hold_level", 32'(fifo_level), 32'd8);
    run_en = 1'b1;
    tick();
    tick();
    check("full_pop_sample", 32'(fir_sample), 32'h01);
    check("full_pop_level", 32'(fifo_level), 32'd7);
    check("full_pop_s_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    $display("push 0x09 after space -> level %0d", fifo_level);
    check("ninth_level", 32'(fifo_level), 32'd8);
    check("ninth_s_ready", 32'(s_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
